pwm_fade_engine: RTL and testbench
==================================

# pwm_fade_engine

Parametrised N-channel PWM generator with per-channel linear fading, the next-generation replacement for the fixed four-channel RGBW PWM stage. It sits between the colour processing path (or SPI dispatcher) and the LED pins. Duty targets arrive over a valid/ready write port. Active duties change only at PWM period boundaries, so outputs never glitch, and each channel can ramp towards its target at a programmable per-period step.

## Interface
Parameters:
- `CHANNELS`, default 4: number of PWM outputs (1..16).
- `WIDTH`, default 8: duty and counter width in bits (4..12).
- `STEP_W`, default 4: width of the per-channel fade step.

Ports:
- `clk` in 1: single system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `tick_en` in 1: counter advance enable, driven by the prescaler; the block holds state when low.
- `wr_valid` in 1: write request.
- `wr_ready` out 1: write accept. A transfer occurs on a `clk` edge where `wr_valid && wr_ready`.
- `wr_ch` in `$clog2(CHANNELS)` (min 1): target channel.
- `wr_duty` in `WIDTH`: target duty; 0 = always off, 2^WIDTH−1 = always on.
- `wr_step` in `STEP_W`: fade step per period; 0 = jump.
- `pwm_out` out `CHANNELS`: registered PWM outputs.
- `period_start` out 1: one-`clk` pulse on counter wrap.
- `fading` out `CHANNELS`: high while a channel's active duty ≠ its target.

## Operation
- Period counter `cnt` runs 0..2^WIDTH−2 and advances on each `clk` with `tick_en`=1.
  - Period = 2^WIDTH−1 ticks.
  - Wrap is the tick where `cnt`=2^WIDTH−2; `cnt` becomes 0.
- `pwm_out[i]` is registered from (`cnt` < `active[i]`), evaluated only on `tick_en` cycles.
  - `active`=0 gives constant low; `active`=2^WIDTH−1 gives constant high.
- Write path:
  - An accepted write loads a one-entry staging register and drops `wr_ready` for exactly one cycle.
  - The next cycle copies staging into `target[wr_ch]` and `step[wr_ch]`, then `wr_ready` returns high.
  - `wr_ch` ≥ `CHANNELS`: the write is accepted and discarded; no state changes.
- Boundary update, applied to all channels on the wrap tick using the `target` values as they stand that cycle:
  - If `step`=0 or |target−active| ≤ `step`, then `active` = `target`.
  - Otherwise `active` moves towards `target` by `step`.
  - Arithmetic is unsigned in WIDTH+1 bits, with no overflow or underflow.
- A new write during a fade replaces `target`/`step`; the ramp continues from the current `active`.
- `fading[i]` = (`active[i]` ≠ `target[i]`), registered.

## Timing
- Reset values: `cnt`=0, all `active`/`target`/`step`=0, `pwm_out`=0, `period_start`=0, `fading`=0, `wr_ready`=1.
- Reset is asynchronous: assertion forces all outputs to their reset values immediately, including mid-period.
- Write-to-target latency: 2 `clk` cycles.
- Target-to-output: takes effect at the first wrap tick at least one cycle after `target` is written.
- A write whose `target` update lands on the wrap cycle itself is applied at the following wrap.
- `pwm_out` lags `cnt` by one `clk`.
- `period_start` is asserted in the cycle after the wrap tick, the same cycle the new `active` is visible.
- `tick_en`=0 freezes `cnt`, `active` and `pwm_out`. Writes are still accepted.

## Configuration
- `PWM_FADE_ENGINE_FADE_EN` defined:
  - Step/ramp logic and `step` storage are compiled in, as described above.
- Undefined:
  - `wr_step` is ignored; `active` = `target` at every wrap.
  - `fading[i]` is high from the target write until the next wrap.
  - No `step` registers are built.

## Test plan
- **Basic duty:** WIDTH=8, `tick_en`=1; write ch0 duty 64, step 0.
  - After the next `period_start`, `pwm_out[0]` is high for exactly 64 of every 255 clocks.
  - `pwm_out[3:1]` stay 0.
- **Extremes:** ch1 duty 0, ch2 duty 255.
  - Over 3 full periods, `pwm_out[1]` is constant 0 and `pwm_out[2]` is constant 1.
- **Fade** (FADE_EN): ch1 from 0, write duty 100, step 30.
  - `active` is 30, 60, 90, 100 at four successive wraps.
  - `fading[1]` drops after the 4th wrap.
  - A downward write of 0 with step 50 gives 50, 0.
- **Prescale:** `tick_en` high every 2nd clk.
  - Period = 510 clks, and `period_start` spacing = 510.
- **Handshake:** back-to-back `wr_valid`.
  - `wr_ready` pattern is 1,0,1,0 and every write lands.
  - `wr_ch`=5 with CHANNELS=4 is accepted and causes no change.
- **Reset mid-fade:** assert `rst_n`=0 at `cnt`=100.
  - `pwm_out`, `fading` and `period_start` go 0 immediately.
  - After release, all outputs stay 0 until new writes.

Source files
------------

// File: rtl/pwm_fade_engine.sv
`default_nettype none
// pwm_fade_engine: N-channel PWM with period-aligned duty updates and optional linear fading.
// Define PWM_FADE_ENGINE_FADE_EN to build the per-channel step/ramp logic; otherwise targets jump at the next wrap.
module pwm_fade_engine #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int STEP_W   = 4
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic                                               tick_en,
  input  logic                                               wr_valid,
  output logic                                               wr_ready,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] wr_ch,
  input  logic [WIDTH-1:0]                                   wr_duty,
  input  logic [STEP_W-1:0]                                  wr_step,
  output logic [CHANNELS-1:0]                                pwm_out,
  output logic                                               period_start,
  output logic [CHANNELS-1:0]                                fading
);

  localparam int                CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int                EW       = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;
  localparam logic [WIDTH-1:0]  CNT_LAST = WIDTH'((1 << WIDTH) - 2);
  localparam logic [CH_W:0]     CH_LIMIT = (CH_W + 1)'(CHANNELS);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STAGED = 1'b1
  } wr_state_t;

  wr_state_t         state;
  wr_state_t         state_nx;
  logic              accept;
  logic              commit;
  logic [CH_W-1:0]   stg_ch;
  logic [WIDTH-1:0]  stg_duty;
  logic [WIDTH-1:0]  cnt;
  logic              wrap;

  // Period counter: the last count of the period is the only point where duties change.
  assign wrap = tick_en && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= wrap;
      if (tick_en) begin
        cnt <= wrap ? '0 : cnt + 1'b1;
      end
    end
  end

  // Write handshake: one-entry staging, so ready drops for exactly one cycle per accepted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wr_valid) begin
          accept   = 1'b1;
          state_nx = ST_STAGED;
        end
      end
      ST_STAGED: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  assign wr_ready = (state == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_ch   <= '0;
      stg_duty <= '0;
    end else if (accept) begin
      stg_ch   <= wr_ch;
      stg_duty <= wr_duty;
    end
  end

  // Out-of-range channels are accepted but never committed.
  assign commit = (state == ST_STAGED) && ({1'b0, stg_ch} < CH_LIMIT);

`ifdef PWM_FADE_ENGINE_FADE_EN
  logic [STEP_W-1:0] stg_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_step <= '0;
    end else if (accept) begin
      stg_step <= wr_step;
    end
  end
`else
  logic unused_step;
  assign unused_step = ^wr_step;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic             sel;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] target_nx;
    logic [WIDTH-1:0] active;
    logic [WIDTH-1:0] active_nx;
    logic             pwm_q;
    logic             fading_q;
    logic             fading_nx;

    assign sel       = commit && (stg_ch == CH_W'(i));
    assign target_nx = sel ? stg_duty : target;

`ifdef PWM_FADE_ENGINE_FADE_EN
    logic [STEP_W-1:0] step;
    logic [EW-1:0]     dist;
    logic [EW-1:0]     step_e;

    // Ramp uses the target as it stands this cycle; a commit landing on the wrap waits a period.
    always_comb begin
      step_e    = EW'(step);
      dist      = (target > active) ? (EW'(target) - EW'(active))
                                    : (EW'(active) - EW'(target));
      active_nx = active;
      if (wrap) begin
        if ((step == '0) || (dist <= step_e)) begin
          active_nx = target;
        end else if (target > active) begin
          active_nx = WIDTH'(EW'(active) + step_e);
        end else begin
          active_nx = WIDTH'(EW'(active) - step_e);
        end
      end
    end

    assign fading_nx = (active_nx != target_nx);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        step <= '0;
      end else if (sel) begin
        step <= stg_step;
      end
    end
`else
    assign active_nx = wrap ? target : active;
    // Without ramping, a channel is pending from its target write until the next wrap.
    assign fading_nx = sel | (fading_q & ~wrap);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        target   <= '0;
        active   <= '0;
        pwm_q    <= 1'b0;
        fading_q <= 1'b0;
      end else begin
        target   <= target_nx;
        active   <= active_nx;
        fading_q <= fading_nx;
        if (tick_en) begin
          pwm_q <= (cnt < active);
        end
      end
    end

    assign pwm_out[i] = pwm_q;
    assign fading[i]  = fading_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_fade_engine.sv
`default_nettype none
// tb_pwm_fade_engine: directed + randomized checks of pwm_fade_engine against a per-period duty model.
module tb_pwm_fade_engine;

  localparam int CH  = 4;
  localparam int W   = 8;
  localparam int SW  = 6;
  localparam int PER = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick_en = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [1:0]    wr_ch = '0;
  logic [W-1:0]  wr_duty = '0;
  logic [SW-1:0] wr_step = '0;
  logic [CH-1:0] pwm_out;
  logic          period_start;
  logic [CH-1:0] fading;

  logic          wr_valid3 = 1'b0;
  logic          wr_ready3;
  logic [1:0]    wr_ch3 = '0;
  logic [W-1:0]  wr_duty3 = '0;
  logic [SW-1:0] wr_step3 = '0;
  logic [2:0]    pwm_out3;
  logic          unused_ps3;
  logic [2:0]    fading3;

  int vectors = 0;
  int errors  = 0;
  bit prescale = 1'b0;

  int m_act [CH];
  int m_tgt [CH];
  bit m_fad [CH];
`ifdef PWM_FADE_ENGINE_FADE_EN
  int m_stp [CH];
`endif

  pwm_fade_engine #(.CHANNELS(CH), .WIDTH(W), .STEP_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ch(wr_ch),
    .wr_duty(wr_duty), .wr_step(wr_step),
    .pwm_out(pwm_out), .period_start(period_start), .fading(fading)
  );

  pwm_fade_engine #(.CHANNELS(3), .WIDTH(W), .STEP_W(SW)) dut3 (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en),
    .wr_valid(wr_valid3), .wr_ready(wr_ready3), .wr_ch(wr_ch3),
    .wr_duty(wr_duty3), .wr_step(wr_step3),
    .pwm_out(pwm_out3), .period_start(unused_ps3), .fading(fading3)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      tick_en = prescale ? ~tick_en : 1'b1;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Spec rule at a wrap: jump if step is 0 or within one step, else move by step.
  function automatic void model_wrap();
    for (int i = 0; i < CH; i++) begin
`ifdef PWM_FADE_ENGINE_FADE_EN
      int d;
      d = m_tgt[i] - m_act[i];
      if (m_stp[i] == 0 || ((d < 0) ? -d : d) <= m_stp[i]) m_act[i] = m_tgt[i];
      else m_act[i] = m_act[i] + ((d > 0) ? m_stp[i] : -m_stp[i]);
      m_fad[i] = (m_act[i] != m_tgt[i]);
`else
      m_act[i] = m_tgt[i];
      m_fad[i] = 1'b0;
`endif
    end
  endfunction

  function automatic void model_write(input int ch, input int duty, input int stp);
    m_tgt[ch] = duty;
`ifdef PWM_FADE_ENGINE_FADE_EN
    m_stp[ch] = stp;
    m_fad[ch] = (m_act[ch] != duty);
`else
    m_fad[ch] = (stp >= 0);
`endif
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < CH; i++) begin
      m_act[i] = 0;
      m_tgt[i] = 0;
      m_fad[i] = 1'b0;
`ifdef PWM_FADE_ENGINE_FADE_EN
      m_stp[i] = 0;
`endif
    end
  endfunction

  task automatic wait_ps();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (period_start !== 1'b1 && n < 2000);
    chk("period_start_seen", period_start, 1);
    model_wrap();
  endtask

  // Called in a period_start cycle; counts high cycles over one full period and ends on the next one.
  task automatic measure(input int k, output int c1);
    int hi [CH];
    int ps_seen;
    ps_seen = 0;
    for (int i = 0; i < CH; i++) hi[i] = 0;
    for (int c = 1; c <= PER * k; c++) begin
      @(negedge clk);
      for (int i = 0; i < CH; i++) if (pwm_out[i] === 1'b1) hi[i]++;
      if (period_start === 1'b1) ps_seen += (c == PER * k) ? 1 : 100;
    end
    for (int i = 0; i < CH; i++) chk($sformatf("duty_ch%0d", i), hi[i], k * m_act[i]);
    chk("period_length", ps_seen, 1);
    c1 = hi[1];
    model_wrap();
    for (int i = 0; i < CH; i++) chk($sformatf("fading_ch%0d", i), fading[i], m_fad[i]);
  endtask

  task automatic do_write(input int ch, input int duty, input int stp);
    wr_valid = 1'b1;
    wr_ch    = 2'(ch);
    wr_duty  = W'(duty);
    wr_step  = SW'(stp);
    chk("ready_idle", wr_ready, 1);
    @(negedge clk);
    wr_valid = 1'b0;
    chk("ready_busy", wr_ready, 0);
    @(negedge clk);
    chk("ready_back", wr_ready, 1);
    model_write(ch, duty, stp);
    chk("fading_on_write", fading[ch], m_fad[ch]);
  endtask

  initial begin
    int c1;
    int bad;
    int hs_duty [4];
    int fade_up [4];
    int fade_dn [2];
    hs_duty = '{64, 0, 255, 0};
    fade_up = '{30, 60, 90, 100};
    fade_dn = '{50, 0};
    model_reset();

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_pwm", pwm_out, 0);
    chk("reset_fading", fading, 0);
    chk("reset_period_start", period_start, 0);
    chk("reset_ready", wr_ready, 1);

    // Out-of-range channel on a 3-channel instance: accepted, discarded.
    wr_valid3 = 1'b1; wr_ch3 = 2'd3; wr_duty3 = 8'd200; wr_step3 = '0;
    chk("oor_ready_idle", wr_ready3, 1);
    @(negedge clk);
    wr_valid3 = 1'b0;
    chk("oor_ready_busy", wr_ready3, 0);
    @(negedge clk);
    chk("oor_ready_back", wr_ready3, 1);
    chk("oor_fading", fading3, 0);

    // Back-to-back handshake: ready toggles 1,0,1,0 with valid held high.
    wr_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      wr_ch   = 2'(j);
      wr_duty = W'(hs_duty[j]);
      wr_step = '0;
      chk("hs_ready_high", wr_ready, 1);
      @(negedge clk);
      chk("hs_ready_low", wr_ready, 0);
      if (j < 3) @(negedge clk);
    end
    wr_valid = 1'b0;
    @(negedge clk);
    chk("hs_ready_final", wr_ready, 1);
    for (int j = 0; j < 4; j++) begin
      model_write(j, hs_duty[j], 0);
      chk($sformatf("hs_fading_ch%0d", j), fading[j], m_fad[j]);
    end

    // Basic duty and extremes over three periods.
    wait_ps();
    for (int p = 0; p < 3; p++) measure(1, c1);

    // Prescaled ticks: every period doubles in clocks.
    prescale = 1'b1;
    wait_ps();
    measure(2, c1);
    measure(2, c1);
    prescale = 1'b0;
    wait_ps();

    // Randomized writes, each followed by one settling period and one measured period.
    for (int it = 0; it < 8; it++) begin
      do_write($urandom_range(0, CH - 1), $urandom_range(0, PER), $urandom_range(0, (1 << SW) - 1));
      wait_ps();
      measure(1, c1);
    end

`ifdef PWM_FADE_ENGINE_FADE_EN
    do_write(1, 0, 0);
    wait_ps();
    do_write(1, 100, 30);
    wait_ps();
    for (int j = 0; j < 4; j++) begin
      measure(1, c1);
      chk($sformatf("fade_up_%0d", j), c1, fade_up[j]);
    end
    chk("fade_up_done", fading[1], 0);
    do_write(1, 0, 50);
    wait_ps();
    for (int j = 0; j < 2; j++) begin
      measure(1, c1);
      chk($sformatf("fade_down_%0d", j), c1, fade_dn[j]);
    end
    chk("fade_down_done", fading[1], 0);
`endif

    // Asynchronous reset in the middle of a period.
    do_write(2, 255, 0);
    do_write(1, 200, 10);
    wait_ps();
    repeat (100) @(negedge clk);
    chk("pre_reset_ch2_high", pwm_out[2], 1);
    chk("oor_no_effect_pwm", pwm_out3, 0);
    chk("oor_no_effect_fading", fading3, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_pwm", pwm_out, 0);
    chk("async_reset_fading", fading, 0);
    chk("async_reset_period_start", period_start, 0);
    chk("async_reset_ready", wr_ready, 1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (pwm_out !== '0 || fading !== '0 || wr_ready !== 1'b1) bad++;
    end
    chk("post_reset_quiet_cycles", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
